// File: rtl/gpio_checkpoint_monitor.sv
// ---------------------------------------------------------------------------
// gpio_checkpoint_monitor
//
// Watches a GPIO-derived status bus for an ordered list of firmware progress
// codes. A value is accepted only after it has been held for STABLE_CYCLES
// consecutive samples, so short glitches are filtered. Accepted values are
// matched against the code list in order. The sequence must complete within
// TIMEOUT_CYCLES of arming.
//
// Optional feature (macro GPIO_CKPT_ORDER_CHECK_EN):
//   When defined, an accepted value that equals a code later in the list than
//   the next expected one ends the run as an order error (fail_code = 2).
//   When undefined, such values are ignored.
//
// Ports:
//   clock     in   sole clock, rising edge
//   resetb    in   asynchronous active-low reset
//   enable    in   level; high arms the monitor, low returns it to idle
//   probe     in   [WIDTH] observed status bus (asynchronous, registered here)
//   step_idx  out  number of codes matched so far
//   started   out  first code matched
//   passed    out  all codes matched in order
//   failed    out  timeout or order error
//   fail_code out  [2] 0 none, 1 timeout, 2 order error
//   done      out  passed | failed
//   elapsed   out  cycles since arming, frozen once done
// ---------------------------------------------------------------------------
module gpio_checkpoint_monitor #(
    parameter int                          WIDTH          = 16,
    parameter int                          NUM_STEPS      = 2,
    parameter logic [NUM_STEPS*WIDTH-1:0]  EXPECTED       = {16'hAB61, 16'hAB60},
    parameter int                          STABLE_CYCLES  = 4,
    parameter int                          TIMEOUT_CYCLES = 75000
) (
    input  logic                                  clock,
    input  logic                                  resetb,
    input  logic                                  enable,
    input  logic [WIDTH-1:0]                      probe,
    output logic [$clog2(NUM_STEPS+1)-1:0]        step_idx,
    output logic                                  started,
    output logic                                  passed,
    output logic                                  failed,
    output logic [1:0]                            fail_code,
    output logic                                  done,
    output logic [$clog2(TIMEOUT_CYCLES+1)-1:0]   elapsed
);

    localparam int STEP_W = $clog2(NUM_STEPS + 1);
    localparam int EL_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int STAB_W = $clog2(STABLE_CYCLES + 1);

`ifdef GPIO_CKPT_ORDER_CHECK_EN
    localparam logic ORDER_CHECK = 1'b1;
`else
    localparam logic ORDER_CHECK = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_RUN,
        S_PASS,
        S_FAIL
    } state_t;

    state_t              state;
    logic [WIDTH-1:0]    probe_q;
    logic [STAB_W-1:0]   stab_cnt;
    logic [STAB_W-1:0]   stab_next;
    logic                accept;
    logic                match_cur;
    logic                match_ahead;
    logic                last_step;
    logic [EL_W-1:0]     elapsed_next;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        stab_next = '0;
        if (probe != probe_q) begin
            stab_next = '0;
        end else if (stab_cnt == STAB_W'(STABLE_CYCLES)) begin
            stab_next = stab_cnt;
        end else begin
            stab_next = stab_cnt + STAB_W'(1);
        end
    end

    // Compare the accepted value (still held in probe_q) against the code
    // list relative to the next expected step.
    always_comb begin
        match_cur   = 1'b0;
        match_ahead = 1'b0;
        for (int j = 0; j < NUM_STEPS; j++) begin
            if (probe_q == EXPECTED[j*WIDTH +: WIDTH]) begin
                if (j == int'(step_idx)) begin
                    match_cur = 1'b1;
                end else if (j > int'(step_idx)) begin
                    match_ahead = 1'b1;
                end
            end
        end
    end

    assign last_step    = (int'(step_idx) == NUM_STEPS - 1);
    assign elapsed_next = elapsed + EL_W'(1);

    // Input stage. The accept strobe is registered on the edge where the run
    // length first reaches STABLE_CYCLES-1; the count then moves on to its
    // saturation value, so a held value produces exactly one strobe.
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees pre-edge values of the others, independent of statement order.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            probe_q  <= '0;
            stab_cnt <= '0;
            accept   <= 1'b0;
        end else begin
            probe_q  <= probe;
            stab_cnt <= stab_next;
            accept   <= (stab_next == STAB_W'(STABLE_CYCLES - 1));
        end
    end

    // Sequence FSM with registered status outputs.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state     <= S_IDLE;
            step_idx  <= '0;
            started   <= 1'b0;
            passed    <= 1'b0;
            failed    <= 1'b0;
            fail_code <= 2'd0;
            done      <= 1'b0;
            elapsed   <= '0;
        end else if (!enable) begin
            state     <= S_IDLE;
            step_idx  <= '0;
            started   <= 1'b0;
            passed    <= 1'b0;
            failed    <= 1'b0;
            fail_code <= 2'd0;
            done      <= 1'b0;
            elapsed   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state   <= S_ARMED;
                    elapsed <= '0;
                end
                S_ARMED, S_RUN: begin
                    elapsed <= elapsed_next;
                    if (accept && match_cur) begin
                        started  <= 1'b1;
                        step_idx <= step_idx + STEP_W'(1);
                    end
                    // A final match beats a timeout landing on the same edge.
                    if (accept && match_cur && last_step) begin
                        state  <= S_PASS;
                        passed <= 1'b1;
                        done   <= 1'b1;
                    end else if (ORDER_CHECK && accept && !match_cur && match_ahead) begin
                        state     <= S_FAIL;
                        failed    <= 1'b1;
                        fail_code <= 2'd2;
                        done      <= 1'b1;
                    end else if (elapsed_next == EL_W'(TIMEOUT_CYCLES)) begin
                        state     <= S_FAIL;
                        failed    <= 1'b1;
                        fail_code <= 2'd1;
                        done      <= 1'b1;
                    end else if (accept && match_cur) begin
                        state <= S_RUN;
                    end
                end
                default: begin
                    // PASS and FAIL hold every output until enable drops.
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: doc/gpio_checkpoint_monitor.md
# gpio_checkpoint_monitor

Parametrised, synthesizable checkpoint monitor that watches a GPIO-derived status bus (e.g. `mprj_io[31:16]`) for an ordered sequence of firmware progress codes. Input glitches are filtered, the start and completion of the sequence are flagged, and an overall cycle budget is enforced. It generalises the fixed two-code, fixed-timeout pass/fail monitor used in the mega-project IO and logic-analyzer tests. It is usable both inside a user-project wrapper for on-chip self-test and as a reusable bench component.

## Interface
Parameters:
- `WIDTH`, 16: width of the observed status bus.
- `NUM_STEPS`, 2: number of ordered checkpoint codes. Legal range 1..8.
- `EXPECTED`, {16'hAB61, 16'hAB60}: packed `NUM_STEPS*WIDTH` code list. Step 0 occupies the LSBs.
- `STABLE_CYCLES`, 4: consecutive identical samples required to accept a value. Must be ≥1.
- `TIMEOUT_CYCLES`, 75000: cycle budget from arming to pass. Must be ≥2.

Ports:
- `clock`  in  1  sole clock; all logic on the rising edge.
- `resetb`  in  1  asynchronous, active-low reset.
- `enable`  in  1  level; high arms the monitor, low returns it to IDLE.
- `probe`  in  WIDTH  observed status bus; asynchronous, registered internally.
- `step_idx`  out  clog2(NUM_STEPS+1)  number of steps matched so far.
- `started`  out  1  step 0 matched.
- `passed`  out  1  all steps matched in order.
- `failed`  out  1  timeout or order error.
- `fail_code`  out  2  0 = none, 1 = timeout, 2 = order error.
- `done`  out  1  `passed | failed`.
- `elapsed`  out  clog2(TIMEOUT_CYCLES+1)  cycles since arming; frozen at done.

## Operation
- Reset: every output is 0. State is IDLE. Internal probe register is 0, stability count is 0.
- Input stage: `probe_q` samples `probe` every edge. `stab_cnt` clears when `probe` ≠ `probe_q`; otherwise it increments, saturating at `STABLE_CYCLES`.
- Accept strobe: a one-cycle pulse when `stab_cnt` reaches `STABLE_CYCLES-1`. It fires once per stable run. A value that stays constant never re-accepts.
- States: IDLE → ARMED → RUN → PASS or FAIL.
- IDLE:
  - `enable`=1 → ARMED. `elapsed` clears to 0.
  - All status outputs stay cleared.
- ARMED:
  - Accepted value = `EXPECTED[0]` → `started`=1, `step_idx`=1.
  - Then → RUN, or → PASS when `NUM_STEPS`=1.
- RUN:
  - Accepted value = `EXPECTED[step_idx]` → `step_idx`+1.
  - Final step → PASS, `passed`=1.
  - Accepting the previous step's code again is ignored.
- ARMED/RUN, every cycle:
  - `elapsed` increments.
  - Reaching `TIMEOUT_CYCLES` → FAIL, `fail_code`=1.
  - If the final accept and the timeout fall on the same edge, PASS wins.
- PASS and FAIL: terminal. All outputs hold until `enable`=0, which returns to IDLE and clears them.
- `enable` dropping mid-sequence: return to IDLE on the next edge and clear all status outputs. No fail is reported.
- Accepted values that match no code are ignored (a bus idling at 0 is legal).

## Timing
- From a `probe` change to the `step_idx`/`started`/`passed` update is exactly `STABLE_CYCLES+1` rising edges. The value must be held throughout.
- A glitch shorter than `STABLE_CYCLES` samples produces no accept.
- `elapsed` = 1 on the first edge after ARMED is entered. FAIL is asserted on the edge where `elapsed` would reach `TIMEOUT_CYCLES`.
- All outputs are registered. `done` rises on the same edge as `passed` or `failed`.
- An asynchronous `resetb` assertion clears all state immediately, including mid-sequence. Deassertion takes effect on the next edge.

## Configuration
- Macro `GPIO_CKPT_ORDER_CHECK_EN`:
  - Defined: in ARMED or RUN, an accepted value equal to any `EXPECTED[j]` with j > current step → FAIL, `fail_code`=2, on the same edge the accept would otherwise register.
  - Undefined: out-of-order codes are ignored, and `fail_code`=2 never occurs.

## Test plan
- Defaults, `enable`=1. Drive `probe` 16'h0000, then 16'hAB60 for 10 cycles, then 16'hAB61 for 10 cycles.
  - `started` rises 5 edges after AB60 appears.
  - `passed`=1, `step_idx`=2, `fail_code`=0.
- Drive AB60 for 3 cycles only, then 0.
  - No accept. `started` stays 0.
- `TIMEOUT_CYCLES`=100, only AB60 driven.
  - `failed`=1 and `fail_code`=1 at `elapsed`=100.
  - `elapsed` stays frozen at 100.
- With `GPIO_CKPT_ORDER_CHECK_EN` defined, drive AB61 before AB60.
  - `failed`=1, `fail_code`=2.
  - Without the macro, the same stimulus followed by AB60 then AB61 passes.
- Pulse `resetb` low mid-RUN with `step_idx`=1.
  - All outputs go to 0 immediately.
  - The monitor re-arms after release and completes a fresh pass.
- Final accept of AB61 lands on the timeout edge.
  - `passed`=1, `failed`=0.
